// File: rtl/zero_byte_codec.sv
// zero_byte_codec
//   Zero-lane compressor/decompressor, one lane per clock.
//   Compress (mode=0): all-zero lanes are dropped and the non-zero lanes are
//   packed toward lane 0. meta_out marks the non-zero lanes and len_out counts
//   them.
//   Decompress (mode=1): the packed lanes are scattered back to the positions
//   marked in meta_in. Unmarked lanes become zero and meta_out echoes meta_in.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready   input handshake (in_ready decoded from state only)
//   mode                0=compress, 1=decompress, sampled at accept
//   data_in, meta_in    input word and lane mask (mask used in decompress)
//   out_valid/out_ready output handshake
//   data_out, meta_out  result word and lane mask (registered)
//   len_out             number of non-zero / packed lanes (registered)
//   busy                block is not idle (registered)
//   bypass              only with ZBC_BYPASS_EN: pass the word through
//
// Optional feature macro: ZBC_BYPASS_EN
module zero_byte_codec #(
  parameter int LANES  = 32,
  parameter int LANE_W = 8,
  localparam int LW    = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
`ifdef ZBC_BYPASS_EN
  input  logic                    bypass,
`endif
  input  logic [LANES*LANE_W-1:0] data_in,
  input  logic [LANES-1:0]        meta_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] data_out,
  output logic [LANES-1:0]        meta_out,
  output logic [LW-1:0]           len_out,
  output logic                    busy
);

  localparam int IW = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                    state;
  logic [IW-1:0]             idx;
  logic [LANES*LANE_W-1:0]   word;
  logic [LANES-1:0]          mask;
  logic                      mode_r;
  logic [LANE_W-1:0]         lane;
  logic [LANE_W-1:0]         packed_lane;

  assign in_ready    = (state == IDLE);
  assign lane        = word[idx*LANE_W +: LANE_W];
  // len_out never exceeds idx while RUN is active, so this stays in range.
  assign packed_lane = word[len_out*LANE_W +: LANE_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      word      <= '0;
      mask      <= '0;
      mode_r    <= 1'b0;
      data_out  <= '0;
      meta_out  <= '0;
      len_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word     <= data_in;
            mask     <= meta_in;
            mode_r   <= mode;
            idx      <= '0;
            len_out  <= '0;
            data_out <= '0;
            meta_out <= '0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef ZBC_BYPASS_EN
            if (bypass) begin
              data_out <= data_in;
              meta_out <= '1;
              len_out  <= LW'(LANES);
              state    <= DONE;
            end
`endif
          end
        end

        RUN: begin
          if (!mode_r) begin
            if (lane != '0) begin
              data_out[len_out*LANE_W +: LANE_W] <= lane;
              meta_out[idx] <= 1'b1;
              len_out       <= len_out + 1'b1;
            end else begin
              meta_out[idx] <= 1'b0;
            end
          end else begin
            meta_out[idx] <= mask[idx];
            if (mask[idx]) begin
              data_out[idx*LANE_W +: LANE_W] <= packed_lane;
              len_out <= len_out + 1'b1;
            end else begin
              data_out[idx*LANE_W +: LANE_W] <= '0;
            end
          end
          if (idx == IW'(LANES - 1)) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          // The first DONE cycle only raises out_valid. This gives the
          // one-cycle gap between the last lane and the valid result.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zero_byte_codec.sv
module tb_zero_byte_codec;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int LW     = 3;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    mode = 1'b0;
  logic [LANES*LANE_W-1:0] data_in = '0;
  logic [LANES-1:0]        meta_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [LANES*LANE_W-1:0] data_out;
  logic [LANES-1:0]        meta_out;
  logic [LW-1:0]           len_out;
  logic                    busy;
`ifdef ZBC_BYPASS_EN
  logic                    bypass = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zero_byte_codec #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
`ifdef ZBC_BYPASS_EN
    .bypass    (bypass),
`endif
    .data_in   (data_in),
    .meta_in   (meta_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .meta_out  (meta_out),
    .len_out   (len_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: keep the non-zero lanes in order and record where they were.
  function automatic void model_compress(input logic [31:0] w, output logic [31:0] d,
                                         output logic [3:0] m, output int len);
    byte unsigned q[$];
    byte unsigned b;
    d = '0;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      b = w[i*LANE_W +: LANE_W];
      m[i] = (b != 0);
      if (b != 0) q.push_back(b);
    end
    len = q.size();
    for (int k = 0; k < q.size(); k++) d[k*LANE_W +: LANE_W] = q[k];
  endfunction

  // Reference: give the packed lanes, in order, to the marked positions.
  function automatic void model_decompress(input logic [31:0] p, input logic [3:0] m,
                                           output logic [31:0] d, output int len);
    byte unsigned q[$];
    for (int i = 0; i < LANES; i++) q.push_back(p[i*LANE_W +: LANE_W]);
    d = '0;
    len = 0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        d[i*LANE_W +: LANE_W] = q.pop_front();
        len++;
      end
    end
  endfunction

  // Present one word, accept it, then count cycles until out_valid (bounded).
  task automatic launch(input logic md, input logic [31:0] d, input logic [3:0] m,
                        output int lat);
    chk("in_ready_idle", in_ready, 1);
    mode     = md;
    data_in  = d;
    meta_in  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = $urandom;
    meta_in  = 4'($urandom);
    mode     = 1'($urandom);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] ed, input logic [3:0] em,
                              input int el, input int elat, input int lat);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, data_out, ed);
    chk({tag, "_meta"}, meta_out, em);
    chk({tag, "_len"}, len_out, el);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_hs_in_ready"}, in_ready, 1);
    chk({tag, "_hs_valid"}, out_valid, 0);
    chk({tag, "_hs_busy"}, busy, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] ed, w, d0;
    logic [3:0] em, m0;
    logic [LW-1:0] l0;
    int el;
    logic md;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);
    chk("rst_meta", meta_out, 0);
    chk("rst_len", len_out, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed words
    launch(1'b0, 32'h00AB_00CD, 4'b0000, lat);
    check_result("cmp_mixed", 32'h0000_ABCD, 4'b0101, 2, 5, lat);
    handshake("cmp_mixed");

    launch(1'b1, 32'h0000_ABCD, 4'b0101, lat);
    check_result("dec_mixed", 32'h00AB_00CD, 4'b0101, 2, 5, lat);
    handshake("dec_mixed");

    launch(1'b0, 32'h0000_0000, 4'b1111, lat);
    check_result("cmp_zero", 32'h0000_0000, 4'b0000, 0, 5, lat);
    handshake("cmp_zero");

    launch(1'b0, 32'h1122_3344, 4'b0000, lat);
    check_result("cmp_full", 32'h1122_3344, 4'b1111, 4, 5, lat);
    handshake("cmp_full");

    // Lanes of the packed word past popcount(meta) are ignored.
    launch(1'b1, 32'hDEAD_BE77, 4'b1000, lat);
    check_result("dec_garbage", 32'h7700_0000, 4'b1000, 1, 5, lat);
    handshake("dec_garbage");

    // Hold out_ready low. Outputs stay frozen and an in_valid pulse is ignored.
    launch(1'b0, 32'h00AB_00CD, 4'b0000, lat);
    check_result("hold", 32'h0000_ABCD, 4'b0101, 2, 5, lat);
    d0 = data_out;
    m0 = meta_out;
    l0 = len_out;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3);
      data_in  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      chk("hold_data", data_out, d0);
      chk("hold_meta", meta_out, m0);
      chk("hold_len", len_out, l0);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake("hold");
    repeat (3) @(posedge clk);
    #1;
    chk("hold_not_queued_valid", out_valid, 0);
    chk("hold_not_queued_busy", busy, 0);

    // Reset while RUN is on lane 2
    mode     = 1'b0;
    data_in  = 32'h1122_3344;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrun_rst_valid", out_valid, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_data", data_out, 0);
    chk("midrun_rst_meta", meta_out, 0);
    chk("midrun_rst_len", len_out, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    launch(1'b1, 32'h0000_ABCD, 4'b0101, lat);
    check_result("post_rst", 32'h00AB_00CD, 4'b0101, 2, 5, lat);
    handshake("post_rst");

`ifdef ZBC_BYPASS_EN
    bypass = 1'b1;
    launch(1'b1, 32'h00AB_00CD, 4'b0000, lat);
    bypass = 1'b0;
    check_result("bypass", 32'h00AB_00CD, 4'b1111, 4, 1, lat);
    handshake("bypass");
`endif

    // Randomized words against the reference model
    for (int n = 0; n < 24; n++) begin
      md = 1'($urandom);
      w  = '0;
      for (int i = 0; i < LANES; i++)
        w[i*LANE_W +: LANE_W] = $urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      em = 4'($urandom);
      if (!md) begin
        model_compress(w, ed, em, el);
        launch(1'b0, w, 4'($urandom), lat);
      end else begin
        w = $urandom;
        model_decompress(w, em, ed, el);
        launch(1'b1, w, em, lat);
      end
      check_result(md ? "rand_dec" : "rand_cmp", ed, em, el, 5, lat);
      handshake("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
